// File: rtl/paddle_input_conditioner.sv
// Turns raw left/right paddle buttons into debounced levels and rate-limited,
// mutually exclusive single-cycle move pulses for the paddle stage.
module paddle_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int MOVE_PERIOD     = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic game_run,
  input  logic left_btn_raw,
  input  logic right_btn_raw,
  output logic left_level,
  output logic right_level,
  output logic left_move,
  output logic right_move
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RW = $clog2(MOVE_PERIOD);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RATE_LAST = RW'(MOVE_PERIOD - 1);

  typedef enum logic [1:0] {DIR_NONE, DIR_LEFT, DIR_RIGHT} dir_t;
  typedef enum logic {IDLE, REPEAT} state_t;

  // Bit 0 is the left button, bit 1 the right button throughout.
  logic [1:0]    meta;
  logic [1:0]    sync;
  logic [1:0]    level;
  logic [DW-1:0] db_cnt [2];

  state_t        state;
  state_t        state_next;
  dir_t          dir;
  dir_t          prev_dir;
  dir_t          prev_dir_next;
  logic [RW-1:0] rate_cnt;
  logic [RW-1:0] rate_next;
  logic          active;
  logic          pulse;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      sync <= '0;
    end else begin
      meta <= {right_btn_raw, left_btn_raw};
      sync <= meta;
    end
  end

  // The level only flips after sync has disagreed with it for a full window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= '0;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync[i] == level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          level[i]  <= sync[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DW'(1);
        end
      end
    end
  end

  assign left_level  = level[0];
  assign right_level = level[1];

  always_comb begin
    dir = DIR_NONE;
    if (level[0] && !level[1])      dir = DIR_LEFT;
    else if (level[1] && !level[0]) dir = DIR_RIGHT;
  end

  assign active = game_run && (dir != DIR_NONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (active)  state_next = REPEAT;
      REPEAT:  if (!active) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A direction change without passing NONE restarts the period with a pulse.
  always_comb begin
    pulse         = 1'b0;
    rate_next     = '0;
    prev_dir_next = prev_dir;
    case (state)
      IDLE: begin
        if (active) begin
          pulse         = 1'b1;
          prev_dir_next = dir;
        end
      end
      REPEAT: begin
        if (active) begin
          if (dir != prev_dir) begin
            pulse         = 1'b1;
            prev_dir_next = dir;
          end else if (rate_cnt == RATE_LAST) begin
            pulse = 1'b1;
          end else begin
            rate_next = rate_cnt + RW'(1);
          end
        end
      end
      default: begin
        pulse = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rate_cnt   <= '0;
      prev_dir   <= DIR_NONE;
      left_move  <= 1'b0;
      right_move <= 1'b0;
    end else begin
      rate_cnt   <= rate_next;
      prev_dir   <= prev_dir_next;
      left_move  <= pulse && (dir == DIR_LEFT);
      right_move <= pulse && (dir == DIR_RIGHT);
    end
  end

endmodule
